// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register carrying a control and a data bundle over a valid/ready
// handshake, with optional 2-entry skid buffer, flush, bubble injection and counters.
module pipe_stage_reg #(
  parameter int                unsigned CTRL_W   = 16,
  parameter int                unsigned DATA_W   = 165,
  parameter logic [CTRL_W-1:0]          CTRL_NOP = '0,
  parameter int                unsigned SKID     = 1,
  parameter int                unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              skid_valid;
  logic              up;
  logic              down;

  assign up   = in_valid & in_ready;
  assign down = main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // skid_valid is a flop, so in_ready has no combinational path from out_ready
      assign in_ready = ~skid_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_ctrl  <= '0;
          main_data  <= '0;
          skid_ctrl  <= '0;
          skid_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (skid_valid) begin
          if (down) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end else if (up) begin
          if (!main_valid || down) begin
            main_ctrl  <= in_ctrl;
            main_data  <= in_data;
            main_valid <= 1'b1;
          end else begin
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            skid_valid <= 1'b1;
          end
        end else if (down) begin
          main_valid <= 1'b0;
        end
      end
    end else begin : g_single
      assign in_ready   = ~main_valid | out_ready;
      assign skid_valid = 1'b0;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (up) begin
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
          main_valid <= 1'b1;
        end else if (down) begin
          main_valid <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule
